// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: RV32I decode-control stage. Decodes the ID instruction,
// detects load-use hazards, handles flushes and registers the ID/EX control
// bank. Also keeps a saturating count of illegal opcodes.
module id_ctrl_stage #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned ENABLE_JUMP  = 1,
    parameter int unsigned ENABLE_UPPER = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_alu_src,
    output logic                  ex_mem_write,
    output logic                  ex_mem_read,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [1:0]            ex_mem_to_reg,
    output logic [1:0]            ex_op_a_sel,
    output logic [1:0]            ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  illegal_pulse,
    output logic [CNT_W-1:0]      illegal_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic             JUMP_EN  = (ENABLE_JUMP != 0);
    localparam logic             UPPER_EN = (ENABLE_UPPER != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Decoded controls for the ID instruction
    logic       dec_legal_c;
    logic       dec_reg_write_c;
    logic       dec_alu_src_c;
    logic       dec_mem_write_c;
    logic       dec_mem_read_c;
    logic       dec_branch_c;
    logic       dec_jump_c;
    logic [1:0] dec_mem_to_reg_c;
    logic [1:0] dec_op_a_sel_c;
    logic [1:0] dec_alu_op_c;
    logic       rs1_used_c;
    logic       rs2_used_c;
    logic       hazard_c;

    // ID/EX register bank
    logic                  ex_valid_q,      ex_valid_d;
    logic                  ex_reg_write_q,  ex_reg_write_d;
    logic                  ex_alu_src_q,    ex_alu_src_d;
    logic                  ex_mem_write_q,  ex_mem_write_d;
    logic                  ex_mem_read_q,   ex_mem_read_d;
    logic                  ex_branch_q,     ex_branch_d;
    logic                  ex_jump_q,       ex_jump_d;
    logic [1:0]            ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic [1:0]            ex_op_a_sel_q,   ex_op_a_sel_d;
    logic [1:0]            ex_alu_op_q,     ex_alu_op_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,         ex_rd_d;
    logic                  illegal_pulse_q, illegal_pulse_d;
    logic [CNT_W-1:0]      illegal_cnt_q,   illegal_cnt_d;

    // Opcode decode; disabled jump/upper opcodes fall through as illegal
    always_comb begin
        dec_legal_c      = 1'b0;
        dec_reg_write_c  = 1'b0;
        dec_alu_src_c    = 1'b0;
        dec_mem_write_c  = 1'b0;
        dec_mem_read_c   = 1'b0;
        dec_branch_c     = 1'b0;
        dec_jump_c       = 1'b0;
        dec_mem_to_reg_c = 2'b00;
        dec_op_a_sel_c   = 2'b00;
        dec_alu_op_c     = 2'b00;
        rs1_used_c       = 1'b0;
        rs2_used_c       = 1'b0;
        unique case (id_opcode)
            OP_R: begin
                dec_legal_c     = 1'b1;
                dec_reg_write_c = 1'b1;
                dec_alu_op_c    = 2'b10;
                rs1_used_c      = 1'b1;
                rs2_used_c      = 1'b1;
            end
            OP_I_ALU: begin
                dec_legal_c     = 1'b1;
                dec_reg_write_c = 1'b1;
                dec_alu_src_c   = 1'b1;
                dec_alu_op_c    = 2'b11;
                rs1_used_c      = 1'b1;
            end
            OP_LOAD: begin
                dec_legal_c      = 1'b1;
                dec_reg_write_c  = 1'b1;
                dec_alu_src_c    = 1'b1;
                dec_mem_read_c   = 1'b1;
                dec_mem_to_reg_c = 2'b01;
                rs1_used_c       = 1'b1;
            end
            OP_STORE: begin
                dec_legal_c     = 1'b1;
                dec_alu_src_c   = 1'b1;
                dec_mem_write_c = 1'b1;
                rs1_used_c      = 1'b1;
                rs2_used_c      = 1'b1;
            end
            OP_BRANCH: begin
                dec_legal_c  = 1'b1;
                dec_branch_c = 1'b1;
                dec_alu_op_c = 2'b01;
                rs1_used_c   = 1'b1;
                rs2_used_c   = 1'b1;
            end
            OP_JAL: begin
                if (JUMP_EN) begin
                    dec_legal_c      = 1'b1;
                    dec_reg_write_c  = 1'b1;
                    dec_jump_c       = 1'b1;
                    dec_mem_to_reg_c = 2'b10;
                    dec_op_a_sel_c   = 2'b01;
                    dec_alu_src_c    = 1'b1;
                end
            end
            OP_JALR: begin
                if (JUMP_EN) begin
                    dec_legal_c      = 1'b1;
                    dec_reg_write_c  = 1'b1;
                    dec_jump_c       = 1'b1;
                    dec_mem_to_reg_c = 2'b10;
                    dec_alu_src_c    = 1'b1;
                    rs1_used_c       = 1'b1;
                end
            end
            OP_LUI: begin
                if (UPPER_EN) begin
                    dec_legal_c     = 1'b1;
                    dec_reg_write_c = 1'b1;
                    dec_alu_src_c   = 1'b1;
                    dec_op_a_sel_c  = 2'b10;
                end
            end
            OP_AUIPC: begin
                if (UPPER_EN) begin
                    dec_legal_c     = 1'b1;
                    dec_reg_write_c = 1'b1;
                    dec_alu_src_c   = 1'b1;
                    dec_op_a_sel_c  = 2'b01;
                end
            end
            default: ;
        endcase
        // x0 is never written
        if (id_rd == '0) begin
            dec_reg_write_c = 1'b0;
        end
    end

    // Load-use hazard against the load currently in EX
    always_comb begin
        hazard_c = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
                   ((rs1_used_c & (id_rs1 == ex_rd_q)) |
                    (rs2_used_c & (id_rs2 == ex_rd_q)));
    end

    // A flush kills the ID instruction, so holding it would be pointless
    assign stall_id = hazard_c & ~flush;

    // Next-state selection: flush > hazard > no instruction > illegal > load
    always_comb begin
        ex_valid_d      = 1'b0;
        ex_reg_write_d  = 1'b0;
        ex_alu_src_d    = 1'b0;
        ex_mem_write_d  = 1'b0;
        ex_mem_read_d   = 1'b0;
        ex_branch_d     = 1'b0;
        ex_jump_d       = 1'b0;
        ex_mem_to_reg_d = 2'b00;
        ex_op_a_sel_d   = 2'b00;
        ex_alu_op_d     = 2'b00;
        ex_rd_d         = '0;
        illegal_pulse_d = 1'b0;
        illegal_cnt_d   = illegal_cnt_q;
        if (flush || hazard_c || !id_valid) begin
            // bubble
        end else if (!dec_legal_c) begin
            illegal_pulse_d = 1'b1;
            if (illegal_cnt_q != CNT_MAX) begin
                illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d      = 1'b1;
            ex_reg_write_d  = dec_reg_write_c;
            ex_alu_src_d    = dec_alu_src_c;
            ex_mem_write_d  = dec_mem_write_c;
            ex_mem_read_d   = dec_mem_read_c;
            ex_branch_d     = dec_branch_c;
            ex_jump_d       = dec_jump_c;
            ex_mem_to_reg_d = dec_mem_to_reg_c;
            ex_op_a_sel_d   = dec_op_a_sel_c;
            ex_alu_op_d     = dec_alu_op_c;
            ex_rd_d         = id_rd;
        end
    end

    // ID/EX register bank and illegal-opcode counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_branch_q     <= 1'b0;
            ex_jump_q       <= 1'b0;
            ex_mem_to_reg_q <= 2'b00;
            ex_op_a_sel_q   <= 2'b00;
            ex_alu_op_q     <= 2'b00;
            ex_rd_q         <= '0;
            illegal_pulse_q <= 1'b0;
            illegal_cnt_q   <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_branch_q     <= ex_branch_d;
            ex_jump_q       <= ex_jump_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            ex_op_a_sel_q   <= ex_op_a_sel_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_rd_q         <= ex_rd_d;
            illegal_pulse_q <= illegal_pulse_d;
            illegal_cnt_q   <= illegal_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_alu_src    = ex_alu_src_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_branch     = ex_branch_q;
    assign ex_jump       = ex_jump_q;
    assign ex_mem_to_reg = ex_mem_to_reg_q;
    assign ex_op_a_sel   = ex_op_a_sel_q;
    assign ex_alu_op     = ex_alu_op_q;
    assign ex_rd         = ex_rd_q;
    assign illegal_pulse = illegal_pulse_q;
    assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: a default instance plus a second one
// with jump/upper decode disabled and a 2-bit illegal counter.
module tb_id_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic       en2;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       flush;

    logic       stall_id, ex_valid, ex_reg_write, ex_alu_src, ex_mem_write;
    logic       ex_mem_read, ex_branch, ex_jump, illegal_pulse;
    logic [1:0] ex_mem_to_reg, ex_op_a_sel, ex_alu_op;
    logic [4:0] ex_rd;
    logic [7:0] illegal_cnt;

    logic       stall2, valid2, rw2, as2, mw2, mr2, br2, j2, pulse2;
    logic [1:0] m2r2, opa2, aop2;
    logic [4:0] rd2;
    logic [1:0] cnt2;

    logic [11:0] ctl;
    assign ctl = {ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_branch,
                  ex_jump, ex_mem_to_reg, ex_op_a_sel, ex_alu_op};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ctrl_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_op_a_sel(ex_op_a_sel), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .illegal_pulse(illegal_pulse), .illegal_cnt(illegal_cnt)
    );

    id_ctrl_stage #(.ENABLE_JUMP(0), .ENABLE_UPPER(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid & en2), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall_id(stall2), .ex_valid(valid2), .ex_reg_write(rw2),
        .ex_alu_src(as2), .ex_mem_write(mw2), .ex_mem_read(mr2),
        .ex_branch(br2), .ex_jump(j2), .ex_mem_to_reg(m2r2),
        .ex_op_a_sel(opa2), .ex_alu_op(aop2), .ex_rd(rd2),
        .illegal_pulse(pulse2), .illegal_cnt(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [6:0] op, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] rd, input logic fl);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
        flush     = fl;
    endtask

    // Pulse reset low asynchronously in the middle of a cycle
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Put a load in EX, then reset asynchronously mid-cycle
        present(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd5, 1'b0);
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: ex_valid=%b mem_read=%b want 1 1", ex_valid, ex_mem_read);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== 12'h000 || ex_valid !== 1'b0 || ex_rd !== 5'd0 || illegal_pulse !== 1'b0 ||
            illegal_cnt !== 8'd0 || stall_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: ctl=%h valid=%b rd=%0d pulse=%b cnt=%0d stall=%b want all 0",
                     ctl, ex_valid, ex_rd, illegal_pulse, illegal_cnt, stall_id);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_opcode_sweep();
        logic [6:0]  ops [9];
        logic [11:0] exp [9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        exp = '{12'b1000_0000_0010, 12'b1100_0000_0011, 12'b1101_0001_0000,
                12'b0110_0000_0000, 12'b0000_1000_0001, 12'b1100_0110_0100,
                12'b1100_0110_0000, 12'b1100_0000_1000, 12'b1100_0000_0100};
        for (int i = 0; i < 9; i++) begin
            present(1'b1, ops[i], 5'd1, 5'd2, 5'd5, 1'b0);
            step();
            checks++;
            if (ctl !== exp[i] || ex_valid !== 1'b1 || ex_rd !== 5'd5) begin
                errors++;
                $display("FAIL sweep_rd5[%0d]: ctl=%b valid=%b rd=%0d want %b 1 5",
                         i, ctl, ex_valid, ex_rd, exp[i]);
            end
        end
        for (int i = 0; i < 9; i++) begin
            present(1'b1, ops[i], 5'd1, 5'd2, 5'd0, 1'b0);
            step();
            checks++;
            if (ctl !== (exp[i] & 12'h7ff) || ex_valid !== 1'b1 || ex_rd !== 5'd0) begin
                errors++;
                $display("FAIL sweep_rd0[%0d]: ctl=%b valid=%b rd=%0d want %b 1 0",
                         i, ctl, ex_valid, ex_rd, exp[i] & 12'h7ff);
            end
        end
    endtask

    task automatic test_load_use();
        present(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd5, 1'b0);  // lw x5
        step();
        present(1'b1, 7'b0110011, 5'd5, 5'd7, 5'd6, 1'b0);  // add x6, x5, x7
        #1;
        checks++;
        if (stall_id !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall_id=%b want 1", stall_id);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ctl !== 12'h000 || ex_rd !== 5'd0 || stall_id !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: valid=%b ctl=%h rd=%0d stall=%b want 0 000 0 0",
                     ex_valid, ctl, ex_rd, stall_id);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ctl !== 12'b1000_0000_0010 || ex_rd !== 5'd6) begin
            errors++;
            $display("FAIL load_use_add: valid=%b ctl=%b rd=%0d want 1 100000000010 6",
                     ex_valid, ctl, ex_rd);
        end
        // Load to x0 never creates a hazard
        present(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd0, 1'b0);
        step();
        present(1'b1, 7'b0110011, 5'd0, 5'd7, 5'd6, 1'b0);
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            errors++;
            $display("FAIL load_x0_stall: stall_id=%b want 0", stall_id);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
            errors++;
            $display("FAIL load_x0_add: valid=%b rd=%0d want 1 6", ex_valid, ex_rd);
        end
    endtask

    task automatic test_flush_hazard();
        present(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd5, 1'b0);
        step();
        present(1'b1, 7'b0100011, 5'd3, 5'd5, 5'd0, 1'b1);  // store using x5 as rs2, flushed
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            errors++;
            $display("FAIL flush_hazard_stall: stall_id=%b want 0", stall_id);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ctl !== 12'h000 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL flush_hazard_bubble: valid=%b ctl=%h rd=%0d want 0 000 0",
                     ex_valid, ctl, ex_rd);
        end
        // Back-to-back flushes of a legal instruction each give a bubble
        present(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd9, 1'b1);
        step();
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL flush_b2b: valid=%b rd=%0d want 0 0", ex_valid, ex_rd);
        end
    endtask

    task automatic test_reset_mid_stall();
        present(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd5, 1'b0);
        step();
        present(1'b1, 7'b0110011, 5'd5, 5'd7, 5'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_id !== 1'b0 || ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_stall: stall=%b valid=%b mr=%b rd=%0d want 0 0 0 0",
                     stall_id, ex_valid, ex_mem_read, ex_rd);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
            errors++;
            $display("FAIL after_reset_add: valid=%b rd=%0d want 1 6", ex_valid, ex_rd);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        present(1'b1, 7'h7f, 5'd1, 5'd2, 5'd5, 1'b0);
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || illegal_pulse !== 1'b1 || illegal_cnt !== 8'd1) begin
            errors++;
            $display("FAIL illegal_main: valid=%b rd=%0d pulse=%b cnt=%0d want 0 0 1 1",
                     ex_valid, ex_rd, illegal_pulse, illegal_cnt);
        end
        present(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd5, 1'b0);
        step();
        checks++;
        if (illegal_pulse !== 1'b0 || illegal_cnt !== 8'd1 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal_after: pulse=%b cnt=%0d valid=%b want 0 1 1",
                     illegal_pulse, illegal_cnt, ex_valid);
        end
    endtask

    task automatic test_disabled();
        do_reset();
        en2 = 1'b1;
        present(1'b1, 7'b1101111, 5'd1, 5'd2, 5'd5, 1'b0);  // JAL
        step();
        checks++;
        if (valid2 !== 1'b0 || pulse2 !== 1'b1 || cnt2 !== 2'd1 || rd2 !== 5'd0 || j2 !== 1'b0) begin
            errors++;
            $display("FAIL jal_disabled: valid=%b pulse=%b cnt=%0d rd=%0d jump=%b want 0 1 1 0 0",
                     valid2, pulse2, cnt2, rd2, j2);
        end
        checks++;
        if (ex_valid !== 1'b1 || ex_jump !== 1'b1) begin
            errors++;
            $display("FAIL jal_enabled: valid=%b jump=%b want 1 1", ex_valid, ex_jump);
        end
        present(1'b1, 7'b1101111, 5'd1, 5'd2, 5'd5, 1'b1);  // flushed JAL
        step();
        checks++;
        if (pulse2 !== 1'b0 || cnt2 !== 2'd1) begin
            errors++;
            $display("FAIL jal_flushed: pulse=%b cnt=%0d want 0 1", pulse2, cnt2);
        end
        present(1'b0, 7'b1101111, 5'd1, 5'd2, 5'd5, 1'b0);  // not valid
        step();
        checks++;
        if (pulse2 !== 1'b0 || cnt2 !== 2'd1) begin
            errors++;
            $display("FAIL jal_invalid: pulse=%b cnt=%0d want 0 1", pulse2, cnt2);
        end
        present(1'b1, 7'b0110111, 5'd1, 5'd2, 5'd5, 1'b0);  // LUI
        step();
        checks++;
        if (pulse2 !== 1'b1 || cnt2 !== 2'd2 || valid2 !== 1'b0) begin
            errors++;
            $display("FAIL lui_disabled: pulse=%b cnt=%0d valid=%b want 1 2 0", pulse2, cnt2, valid2);
        end
        en2 = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        en2 = 1'b1;
        present(1'b1, 7'h7f, 5'd1, 5'd2, 5'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (cnt2 !== exp_cnt[i] || pulse2 !== 1'b1) begin
                errors++;
                $display("FAIL saturate[%0d]: cnt=%0d pulse=%b want %0d 1", i, cnt2, pulse2, exp_cnt[i]);
            end
        end
        present(1'b0, 7'h7f, 5'd1, 5'd2, 5'd5, 1'b0);
        step();
        checks++;
        if (cnt2 !== 2'd3 || pulse2 !== 1'b0) begin
            errors++;
            $display("FAIL saturate_hold: cnt=%0d pulse=%b want 3 0", cnt2, pulse2);
        end
        en2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en2   = 1'b0;
        present(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checks++;
        if (ctl !== 12'h000 || ex_valid !== 1'b0 || illegal_cnt !== 8'd0 || stall_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: ctl=%h valid=%b cnt=%0d stall=%b want 0", ctl, ex_valid,
                     illegal_cnt, stall_id);
        end
        rst_n = 1'b1;
        step();
        test_reset();
        test_opcode_sweep();
        test_load_use();
        test_flush_hazard();
        test_reset_mid_stall();
        test_illegal();
        test_disabled();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Instruction-decode control stage for the RV32I pipeline. It extends the plain opcode decoder with jump and upper-immediate support (each enabled by a parameter), load-use hazard detection, flush handling and a registered ID/EX control bank. It decodes the ID-stage instruction fields and drives the EX-stage control signals one cycle later. It also keeps a saturating count of illegal opcodes.

## Interface
- REG_ADDR_W, 5, register-index width
- ENABLE_JUMP, 1, decode JAL/JALR; when 0 these opcodes are illegal
- ENABLE_UPPER, 1, decode LUI/AUIPC; when 0 these opcodes are illegal
- CNT_W, 8, illegal-opcode counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  instruction[6:0]
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  source and destination indices
- flush  in  1  branch/jump taken in EX; kill the ID instruction
- stall_id  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_branch, ex_jump  out  1 each  registered controls
- ex_mem_to_reg  out  2  write-back select: 00 ALU, 01 memory, 10 PC+4
- ex_op_a_sel  out  2  ALU operand A: 00 rs1, 01 PC, 10 zero
- ex_alu_op  out  2  to ALU control: 00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- ex_rd  out  REG_ADDR_W  registered destination
- illegal_pulse  out  1  registered; one cycle high per illegal opcode accepted
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes

## Operation
Decode table (unlisted controls are 0; op_a_sel is 00 unless stated):
- R 0110011: reg_write, alu_op 10
- I-ALU 0010011: reg_write, alu_src, alu_op 11
- Load 0000011: reg_write, alu_src, mem_read, mem_to_reg 01, alu_op 00
- Store 0100011: alu_src, mem_write, alu_op 00
- Branch 1100011: branch, alu_op 01
- JAL 1101111: reg_write, jump, mem_to_reg 10, op_a_sel 01, alu_src
- JALR 1100111: reg_write, jump, mem_to_reg 10, alu_src
- LUI 0110111: reg_write, alu_src, op_a_sel 10
- AUIPC 0010111: reg_write, alu_src, op_a_sel 01
- Any other opcode, or a disabled one, is illegal.

Register use:
- rs1 is used by R, I-ALU, Load, Store, Branch and JALR.
- rs2 is used by R, Store and Branch.
- reg_write is forced to 0 when id_rd == 0.

Load-use hazard: hazard = id_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((rs1 used & id_rs1 == ex_rd) | (rs2 used & id_rs2 == ex_rd)).

Next-state priority, evaluated each edge:
1. flush: load a bubble. stall_id = 0 in this cycle even if a hazard exists.
2. hazard: load a bubble. stall_id = 1, so the ID instruction is re-presented next cycle.
3. id_valid = 0: load a bubble.
4. Illegal opcode: load a bubble, set illegal_pulse = 1 next cycle, increment illegal_cnt.
5. Otherwise: load the decoded controls, ex_rd = id_rd, ex_valid = 1.

Other rules:
- A bubble is ex_valid = 0, every ex_* control 0 and ex_rd = 0.
- illegal_pulse is 0 on every edge where rule 4 does not fire.
- A stalled or flushed illegal opcode does not count.
- illegal_cnt saturates at 2^CNT_W − 1 and does not wrap.

## Timing
- Reset (rst_n low, asynchronous): every ex_* output is 0, ex_valid = 0, illegal_pulse = 0, illegal_cnt = 0. stall_id is 0 while reset is held, because ex_valid = 0.
- Decode latency is 1 cycle: inputs in cycle N appear on ex_* in cycle N+1.
- stall_id is purely combinational from the ID inputs and the current ex_* registers; it has no internal state.
- A load-use stall lasts exactly one cycle: the bubble clears ex_mem_read, so the re-presented instruction proceeds on the next edge.
- Back-to-back flushes each insert one bubble.
- If rst_n is asserted mid-stall, the pending bubble is discarded and the block restarts from the reset state.

## Test plan
- Reset: drive rst_n low asynchronously between clock edges with ex_* non-zero -> all outputs 0 immediately, illegal_cnt = 0.
- Opcode sweep: present each of the 9 legal opcodes with rd = 5 -> the ex_* values in the decode table appear one cycle later with ex_valid = 1. Repeat with rd = 0 -> ex_reg_write = 0.
- Load-use: present `lw x5` then `add x6, x5, x7` -> stall_id = 1 for one cycle, one bubble is inserted, the add reaches EX two cycles after the lw. Repeat as `lw x0` then `add x6, x0, x7` -> no stall.
- Flush and hazard together: create a load-use hazard with flush = 1 in the same cycle -> stall_id = 0, bubble loaded, ex_valid = 0.
- Disabled features: with ENABLE_JUMP = 0, present JAL -> bubble, illegal_pulse = 1 for one cycle, illegal_cnt = 1. A stalled or flushed illegal opcode -> no count.
- Counter saturation: with CNT_W = 2, present 5 consecutive illegal opcodes -> illegal_cnt runs 1, 2, 3, 3, 3 and illegal_pulse stays high on every one of those cycles.
